// File: rtl/uart_rx_fifo_if.sv
// Receive-side bus of the UART receiver: serial input, FIFO pop/clear controls,
// FIFO head/level and sticky error flags.
interface uart_rx_fifo_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
);
    logic                          uart_rx;
    logic                          rd_en;
    logic                          err_clr;
    logic [DATA_BITS-1:0]          rd_data;
    logic                          rd_empty;
    logic [$clog2(FIFO_DEPTH):0]   fifo_level;
    logic                          framing_err;
    logic                          parity_err;
    logic                          overrun_err;

    modport slave (
        input  uart_rx, rd_en, err_clr,
        output rd_data, rd_empty, fifo_level, framing_err, parity_err, overrun_err
    );

    modport master (
        output uart_rx, rd_en, err_clr,
        input  rd_data, rd_empty, fifo_level, framing_err, parity_err, overrun_err
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver (configurable data bits / parity) feeding a
// fall-through receive FIFO with sticky framing, parity and overrun flags.
module uart_rx_fifo #(
    parameter int CLK_DIV     = 286,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              lpc_clk,
    input  logic              lpc_rst,
    uart_rx_fifo_if.slave     bus
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLK_DIV);

    localparam logic [CW-1:0] HALF_LOAD  = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD  = CW'(CLK_DIV - 1);
    localparam logic [3:0]    LAST_BIT   = 4'(DATA_BITS - 1);
    localparam logic [AW:0]   LEVEL_FULL = FIFO_DEPTH[AW:0];

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    // ---------------------------------------------------------------------
    // Input synchroniser; idles high so reset never looks like a start edge
    // ---------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;

    // NOTE: clocked state always uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge lpc_clk or posedge lpc_rst) begin
        if (lpc_rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.uart_rx};
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

    // ---------------------------------------------------------------------
    // Frame FSM
    // ---------------------------------------------------------------------
    state_t               state;
    logic                 rx_prev;
    logic [CW-1:0]        cnt;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bad;
    logic                 push_req;
    logic                 frame_err_set;

    always_ff @(posedge lpc_clk or posedge lpc_rst) begin
        if (lpc_rst) begin
            state         <= S_IDLE;
            rx_prev       <= 1'b1;
            cnt           <= '0;
            bit_cnt       <= '0;
            shreg         <= '0;
            par_bad       <= 1'b0;
            push_req      <= 1'b0;
            frame_err_set <= 1'b0;
        end else begin
            rx_prev       <= rx_s;
            push_req      <= 1'b0;
            frame_err_set <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (rx_prev && !rx_s) begin
                        cnt     <= HALF_LOAD;
                        par_bad <= 1'b0;
                        state   <= S_START;
                    end
                end
                S_START: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (rx_s) begin
                        state <= S_IDLE;
                    end else begin
                        cnt     <= FULL_LOAD;
                        bit_cnt <= '0;
                        state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        cnt   <= FULL_LOAD;
                        shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                        if (bit_cnt == LAST_BIT) begin
                            state <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end
                S_PARITY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        cnt     <= FULL_LOAD;
                        // Odd parity needs data^bit == 1, even needs 0.
                        par_bad <= (^shreg) ^ rx_s ^ (PARITY == 1);
                        state   <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (rx_s) begin
                        push_req <= 1'b1;
                        state    <= S_IDLE;
                    end else begin
                        frame_err_set <= 1'b1;
                        state         <= S_BREAK;
                    end
                end
                S_BREAK: begin
                    if (rx_s) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Receive FIFO: counters one bit wider than the pointers to tell full from empty
    // ---------------------------------------------------------------------
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW:0]          wr_cnt;
    logic [AW:0]          rd_cnt;
    logic [AW:0]          level;
    logic                 empty;
    logic                 full;
    logic                 do_pop;
    logic                 do_push;
    logic                 overrun_set;

    assign level       = wr_cnt - rd_cnt;
    assign empty       = (wr_cnt == rd_cnt);
    assign full        = (level == LEVEL_FULL);
    assign do_pop      = bus.rd_en && !empty;
    assign do_push     = push_req && (!full || do_pop);
    assign overrun_set = push_req && full && !do_pop;

    // NOTE: the storage array has no reset; only the counters do, so it maps
    // onto plain RAM and an empty FIFO never exposes its stale contents.
    always_ff @(posedge lpc_clk) begin
        if (do_push) begin
            mem[wr_cnt[AW-1:0]] <= shreg;
        end
    end

    always_ff @(posedge lpc_clk or posedge lpc_rst) begin
        if (lpc_rst) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else begin
            if (do_push) wr_cnt <= wr_cnt + 1'b1;
            if (do_pop)  rd_cnt <= rd_cnt + 1'b1;
        end
    end

    // ---------------------------------------------------------------------
    // Sticky errors: a set event outranks a simultaneous clear
    // ---------------------------------------------------------------------
    logic framing_q;
    logic parity_q;
    logic overrun_q;

    always_ff @(posedge lpc_clk or posedge lpc_rst) begin
        if (lpc_rst) begin
            framing_q <= 1'b0;
            parity_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            framing_q <= frame_err_set          | (framing_q & ~bus.err_clr);
            parity_q  <= (push_req & par_bad)   | (parity_q  & ~bus.err_clr);
            overrun_q <= overrun_set            | (overrun_q & ~bus.err_clr);
        end
    end

    assign bus.rd_data     = empty ? '0 : mem[rd_cnt[AW-1:0]];
    assign bus.rd_empty    = empty;
    assign bus.fifo_level  = level;
    assign bus.framing_err = framing_q;
    assign bus.parity_err  = parity_q;
    assign bus.overrun_err = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: three instances (8N1 depth 16, 8N1 depth 4,
// 8E1 depth 16) driven with hand-built serial frames.
module tb_uart_rx_fifo;

    localparam int CLK_DIV = 286;

    logic       lpc_clk = 1'b0;
    logic       lpc_rst;
    logic [2:0] rx_line;
    logic [2:0] rd_en_v;
    logic [2:0] err_clr_v;

    int n_checks = 0;
    int n_errors = 0;

    always #5 lpc_clk = ~lpc_clk;

    uart_rx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) bus_a ();
    uart_rx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4))  bus_b ();
    uart_rx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) bus_c ();

    assign bus_a.uart_rx = rx_line[0];
    assign bus_a.rd_en   = rd_en_v[0];
    assign bus_a.err_clr = err_clr_v[0];
    assign bus_b.uart_rx = rx_line[1];
    assign bus_b.rd_en   = rd_en_v[1];
    assign bus_b.err_clr = err_clr_v[1];
    assign bus_c.uart_rx = rx_line[2];
    assign bus_c.rd_en   = rd_en_v[2];
    assign bus_c.err_clr = err_clr_v[2];

    uart_rx_fifo #(.CLK_DIV(CLK_DIV), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(16), .SYNC_STAGES(2))
        dut_a (.lpc_clk(lpc_clk), .lpc_rst(lpc_rst), .bus(bus_a));
    uart_rx_fifo #(.CLK_DIV(CLK_DIV), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(4), .SYNC_STAGES(2))
        dut_b (.lpc_clk(lpc_clk), .lpc_rst(lpc_rst), .bus(bus_b));
    uart_rx_fifo #(.CLK_DIV(CLK_DIV), .DATA_BITS(8), .PARITY(2), .FIFO_DEPTH(16), .SYNC_STAGES(2))
        dut_c (.lpc_clk(lpc_clk), .lpc_rst(lpc_rst), .bus(bus_c));

    typedef struct {
        string      name;
        int         idx;
        logic [7:0] exp_data;
        int         exp_level;
    } pop_vec_t;

    pop_vec_t vec_tab [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic get_obs(input int idx, output logic [31:0] level, output logic empty,
                           output logic [7:0] data, output logic fe, output logic pe,
                           output logic oe);
        case (idx)
            0: begin
                level = 32'(bus_a.fifo_level); empty = bus_a.rd_empty; data = bus_a.rd_data;
                fe = bus_a.framing_err; pe = bus_a.parity_err; oe = bus_a.overrun_err;
            end
            1: begin
                level = 32'(bus_b.fifo_level); empty = bus_b.rd_empty; data = bus_b.rd_data;
                fe = bus_b.framing_err; pe = bus_b.parity_err; oe = bus_b.overrun_err;
            end
            default: begin
                level = 32'(bus_c.fifo_level); empty = bus_c.rd_empty; data = bus_c.rd_data;
                fe = bus_c.framing_err; pe = bus_c.parity_err; oe = bus_c.overrun_err;
            end
        endcase
    endtask

    task automatic check_state(input int idx, input string tag, input int exp_level,
                               input logic exp_empty, input logic chk_data,
                               input logic [7:0] exp_data, input logic exp_fe,
                               input logic exp_pe, input logic exp_oe);
        logic [31:0] level;
        logic        empty, fe, pe, oe;
        logic [7:0]  data;
        get_obs(idx, level, empty, data, fe, pe, oe);
        check({tag, ".level"},   level, 32'(exp_level));
        check({tag, ".empty"},   32'(empty), 32'(exp_empty));
        if (chk_data) check({tag, ".data"}, 32'(data), 32'(exp_data));
        check({tag, ".framing"}, 32'(fe), 32'(exp_fe));
        check({tag, ".parity"},  32'(pe), 32'(exp_pe));
        check({tag, ".overrun"}, 32'(oe), 32'(exp_oe));
    endtask

    task automatic hold_bit(input int idx, input logic v);
        rx_line[idx] = v;
        repeat (CLK_DIV) @(negedge lpc_clk);
    endtask

    // Start, 8 data bits LSB first, optional parity, stop; returns at end of stop bit.
    task automatic send_frame(input int idx, input logic [7:0] d, input logic par_en,
                              input logic par_bit, input logic stop_bit);
        hold_bit(idx, 1'b0);
        for (int b = 0; b < 8; b++) hold_bit(idx, d[b]);
        if (par_en) hold_bit(idx, par_bit);
        hold_bit(idx, stop_bit);
    endtask

    task automatic pop(input int idx);
        @(negedge lpc_clk);
        rd_en_v[idx] = 1'b1;
        @(negedge lpc_clk);
        rd_en_v[idx] = 1'b0;
    endtask

    task automatic clear_errors(input int idx);
        @(negedge lpc_clk);
        err_clr_v[idx] = 1'b1;
        @(negedge lpc_clk);
        err_clr_v[idx] = 1'b0;
    endtask

    // Check head/level of each table entry, pop it, then expect the FIFO drained.
    task automatic apply_pops(input int first, input int last, input logic exp_oe);
        for (int i = first; i <= last; i++) begin
            check_state(vec_tab[i].idx, vec_tab[i].name, vec_tab[i].exp_level, 1'b0, 1'b1,
                        vec_tab[i].exp_data, 1'b0, 1'b0, exp_oe);
            pop(vec_tab[i].idx);
        end
        check_state(vec_tab[last].idx, {vec_tab[last].name, "_drained"}, 0, 1'b1, 1'b0,
                    8'h00, 1'b0, 1'b0, exp_oe);
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: time limit reached before the end of the test");
        $fatal(1, "time limit");
    end

    initial begin
        logic [7:0] t2_tx [5];
        logic [7:0] t5_tx [5];

        vec_tab[0]  = '{"t1_pop0", 0, 8'h0F, 2};
        vec_tab[1]  = '{"t1_pop1", 0, 8'hA5, 1};
        vec_tab[2]  = '{"t2_pop0", 0, 8'hF6, 5};
        vec_tab[3]  = '{"t2_pop1", 0, 8'hF7, 4};
        vec_tab[4]  = '{"t2_pop2", 0, 8'hF8, 3};
        vec_tab[5]  = '{"t2_pop3", 0, 8'hF9, 2};
        vec_tab[6]  = '{"t2_pop4", 0, 8'hFA, 1};
        vec_tab[7]  = '{"t5a_pop0", 1, 8'hF0, 4};
        vec_tab[8]  = '{"t5a_pop1", 1, 8'hF1, 3};
        vec_tab[9]  = '{"t5a_pop2", 1, 8'hF2, 2};
        vec_tab[10] = '{"t5a_pop3", 1, 8'hF3, 1};
        vec_tab[11] = '{"t5b_pop0", 1, 8'hF1, 4};
        vec_tab[12] = '{"t5b_pop1", 1, 8'hF2, 3};
        vec_tab[13] = '{"t5b_pop2", 1, 8'hF3, 2};
        vec_tab[14] = '{"t5b_pop3", 1, 8'hF4, 1};
        t2_tx = '{8'hF6, 8'hF7, 8'hF8, 8'hF9, 8'hFA};
        t5_tx = '{8'hF0, 8'hF1, 8'hF2, 8'hF3, 8'hF4};

        lpc_rst   = 1'b1;
        rx_line   = '1;
        rd_en_v   = '0;
        err_clr_v = '0;
        repeat (3) @(negedge lpc_clk);
        check_state(0, "reset_a", 0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        check_state(1, "reset_b", 0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        lpc_rst = 1'b0;
        repeat (5) @(negedge lpc_clk);

        // 1: two frames, read back in order
        send_frame(0, 8'h0F, 1'b0, 1'b0, 1'b1);
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge lpc_clk);
        apply_pops(0, 1, 1'b0);
        pop(0);
        check_state(0, "t1_pop_on_empty", 0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // 2: five frames with no idle gap
        for (int i = 0; i < 5; i++) send_frame(0, t2_tx[i], 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge lpc_clk);
        apply_pops(2, 6, 1'b0);

        // 3: short low pulse is rejected, next frame still decodes
        rx_line[0] = 1'b0;
        repeat (100) @(negedge lpc_clk);
        rx_line[0] = 1'b1;
        repeat (300) @(negedge lpc_clk);
        check_state(0, "t3_glitch", 0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        send_frame(0, 8'hF1, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge lpc_clk);
        check_state(0, "t3_after", 1, 1'b0, 1'b1, 8'hF1, 1'b0, 1'b0, 1'b0);
        pop(0);

        // 4: stop bit 0 then line held low -> one framing error, no push
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b0);
        repeat (1000) @(negedge lpc_clk);
        rx_line[0] = 1'b1;
        repeat (300) @(negedge lpc_clk);
        check_state(0, "t4_break", 0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        clear_errors(0);
        repeat (300) @(negedge lpc_clk);
        check_state(0, "t4_cleared", 0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge lpc_clk);
        check_state(0, "t4_recover", 1, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
        pop(0);

        // 5a: depth-4 FIFO overrun drops the fifth character
        for (int i = 0; i < 5; i++) send_frame(1, t5_tx[i], 1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge lpc_clk);
        apply_pops(7, 10, 1'b1);
        clear_errors(1);
        check_state(1, "t5a_cleared", 0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // 5b: pop in the very cycle the fifth character is written into a full FIFO.
        // Start edge reaches the FSM 2 edges after the first posedge of the start bit;
        // stop is sampled 143+9*286 edges later and written on the edge after that.
        for (int i = 0; i < 4; i++) send_frame(1, t5_tx[i], 1'b0, 1'b0, 1'b1);
        fork
            send_frame(1, t5_tx[4], 1'b0, 1'b0, 1'b1);
            begin
                repeat (2 + CLK_DIV / 2 + 9 * CLK_DIV + 1) @(posedge lpc_clk);
                @(negedge lpc_clk);
                rd_en_v[1] = 1'b1;
                @(negedge lpc_clk);
                rd_en_v[1] = 1'b0;
            end
        join
        repeat (4) @(negedge lpc_clk);
        apply_pops(11, 14, 1'b0);

        // 6: even parity, wrong parity bit still pushes the character
        send_frame(2, 8'hF3, 1'b1, 1'b1, 1'b1);
        repeat (4) @(negedge lpc_clk);
        check_state(2, "t6_parity", 1, 1'b0, 1'b1, 8'hF3, 1'b0, 1'b1, 1'b0);

        // Reset in the middle of a frame discards everything
        rx_line[2] = 1'b0;
        repeat (700) @(negedge lpc_clk);
        lpc_rst = 1'b1;
        repeat (2) @(negedge lpc_clk);
        check_state(2, "t6_in_reset", 0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        rx_line[2] = 1'b1;
        repeat (2) @(negedge lpc_clk);
        lpc_rst = 1'b0;
        repeat (2 * CLK_DIV) @(negedge lpc_clk);
        check_state(2, "t6_after_reset", 0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
